// File: rtl/route_cfg_pkg.sv
// route_cfg_pkg
// Shared definitions for the route configuration sequencer: control-word and
// table-entry geometry, the sequencer state encoding, and the sub-field layout
// of the data_route control word that the table entries carry.
package route_cfg_pkg;

    localparam int CTRL_W     = 36;
    localparam int DEF_BEAT_W = 16;

    // Table entry word is {beats, ctrl}
    localparam int ENT_CTRL_LSB  = 0;
    localparam int ENT_BEATS_LSB = CTRL_W;

    // data_route ctrl layout: nine 4-bit select nibbles, nibble n steers output n
    localparam int CTRL_SEL_W   = 4;
    localparam int CTRL_NUM_SEL = CTRL_W / CTRL_SEL_W;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        APPLY,
        RUN,
        DONE
    } state_t;

    // Bit offset of the select nibble for a given data_route output
    function automatic int ctrl_sel_lsb(input int port);
        return port * CTRL_SEL_W;
    endfunction

endpackage

// File: rtl/route_cfg_table.sv
// route_cfg_table
// Register file holding the route configuration entries. One synchronous
// write port, one combinational read port; reset clears every entry.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   we, waddr,     - write strobe, address and data (entry word)
//   wdata
//   raddr, rdata   - combinational read address and data
module route_cfg_table #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 52
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/route_cfg_sequencer.sv
// route_cfg_sequencer
// Drives data_route's ctrl word from a table of route configurations, holding
// each one for its programmed number of completed beats. The route only changes
// while route_en is low, so the switch fabric never sees ctrl move under a beat.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   cfg_we/addr/wdata   - table write port (ignored while busy)
//   start, num_entries  - run request and entry count (1..DEPTH), IDLE only
//   beat                - one completed handshake on the routed stream
//   ctrl                - route control word to data_route
//   route_en            - traffic enable, high only while running an entry
//   busy, done, err     - activity, end-of-run pulse, sticky illegal-count flag
module route_cfg_sequencer
    import route_cfg_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int BEAT_W = DEF_BEAT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [CTRL_W+BEAT_W-1:0] cfg_wdata,
    input  logic                     start,
    input  logic [AW:0]              num_entries,
    input  logic                     beat,
    output logic [CTRL_W-1:0]        ctrl,
    output logic                     route_en,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int          EW      = CTRL_W + BEAT_W;
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [AW-1:0]       last_q, last_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                err_q, err_d;

    logic [EW-1:0]       entry;
    logic [CTRL_W-1:0]   entry_ctrl;
    logic [BEAT_W-1:0]   entry_beats;
    logic                start_legal;
    logic                at_last;

    route_cfg_table #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (EW)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we && !busy),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (idx_q),
        .rdata (entry)
    );

    assign entry_ctrl  = entry[ENT_CTRL_LSB +: CTRL_W];
    assign entry_beats = entry[ENT_BEATS_LSB +: BEAT_W];
    assign start_legal = (num_entries != '0) && (num_entries <= DEPTH_N);
    assign at_last     = (idx_q == last_q);

    // The final index is captured at start so a run's length cannot be
    // altered by num_entries moving while the sequence is in flight.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_legal) begin
                        idx_d   = '0;
                        last_d  = AW'(num_entries - (AW+1)'(1));
                        err_d   = 1'b0;
                        state_d = READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (entry_beats != '0) begin
                    ctrl_d  = entry_ctrl;
                    cnt_d   = entry_beats;
                    state_d = APPLY;
                end else if (at_last) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            APPLY: begin
                state_d = RUN;
            end
            RUN: begin
                // cnt is left at 1 on the final beat, so it never wraps
                if (beat) begin
                    if (cnt_q == BEAT_W'(1)) begin
                        if (at_last) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = READ;
                        end
                    end else begin
                        cnt_d = cnt_q - BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
        end
    end

    // Pure state decodes, so reset drops route_en without waiting for an edge
    assign ctrl     = ctrl_q;
    assign route_en = (state_q == RUN);
    assign busy     = (state_q == READ) || (state_q == APPLY) || (state_q == RUN);
    assign done     = (state_q == DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_route_cfg_sequencer.sv
// tb_route_cfg_sequencer
// Self-checking bench for route_cfg_sequencer. The reference model expands each
// run into a per-cycle list of expected outputs straight from the entry table:
// one READ cycle per entry, an APPLY cycle plus RUN cycles until that entry's
// beats are consumed for non-zero entries, then one DONE cycle.
module tb_route_cfg_sequencer;
    import route_cfg_pkg::*;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int BEAT_W = 16;
    localparam int EW     = CTRL_W + BEAT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [EW-1:0]     cfg_wdata = '0;
    logic              start = 1'b0;
    logic [AW:0]       num_entries = '0;
    logic              beat = 1'b0;
    logic [CTRL_W-1:0] ctrl;
    logic              route_en, busy, done, err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [CTRL_W-1:0] tbl_ctrl [DEPTH];
    int                tbl_beats [DEPTH];
    logic [CTRL_W-1:0] model_ctrl;
    bit                model_err;

    // Expected per-cycle trace of one run
    logic [CTRL_W-1:0] q_ctrl [$];
    bit                q_en [$];
    bit                q_busy [$];
    bit                q_done [$];
    bit                q_beat [$];

    route_cfg_sequencer #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .BEAT_W (BEAT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .start       (start),
        .num_entries (num_entries),
        .beat        (beat),
        .ctrl        (ctrl),
        .route_en    (route_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drives one cycle's inputs just after the falling edge
    task automatic applyStimulus(input bit st, input logic [AW:0] num, input bit bt,
                                 input bit we, input logic [AW-1:0] addr, input logic [EW-1:0] data);
        @(negedge clk);
        start       = st;
        num_entries = num;
        beat        = bt;
        cfg_we      = we;
        cfg_addr    = addr;
        cfg_wdata   = data;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " ctrl"}, 64'(ctrl), 64'(0));
        checkOutput({tag, " route_en"}, 64'(route_en), 64'(0));
        checkOutput({tag, " busy"}, 64'(busy), 64'(0));
        checkOutput({tag, " done"}, 64'(done), 64'(0));
        checkOutput({tag, " err"}, 64'(err), 64'(0));
    endtask

    task automatic writeEntry(input int i, input int b, input logic [CTRL_W-1:0] cv);
        applyStimulus(1'b0, num_entries, 1'b0, 1'b1, AW'(i), {BEAT_W'(b), cv});
        tbl_ctrl[i]  = cv;
        tbl_beats[i] = b;
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) begin
            tbl_ctrl[i]  = '0;
            tbl_beats[i] = 0;
        end
        model_ctrl = '0;
        model_err  = 1'b0;
    endtask

    function automatic bit randBit(input bit quiet);
        return quiet ? 1'b0 : 1'($urandom_range(0, 1));
    endfunction

    function automatic void pushCycle(input logic [CTRL_W-1:0] c, input bit en, input bit bs,
                                      input bit dn, input bit bt);
        q_ctrl.push_back(c);
        q_en.push_back(en);
        q_busy.push_back(bs);
        q_done.push_back(dn);
        q_beat.push_back(bt);
    endfunction

    // Runs n entries. With use_pat the beats during RUN come from pat (LSB first)
    // and no noise is injected; otherwise beats, stray starts and writes are random.
    task automatic runOne(input int n, input bit use_pat, input logic [31:0] pat);
        logic [CTRL_W-1:0] cur;
        int                rem;
        int                pb;
        bit                bt, st, we;
        q_ctrl.delete(); q_en.delete(); q_busy.delete(); q_done.delete(); q_beat.delete();
        cur = model_ctrl;
        pb  = 0;
        pushCycle(cur, 1'b0, 1'b0, 1'b0, randBit(use_pat));
        for (int i = 0; i < n; i++) begin
            pushCycle(cur, 1'b0, 1'b1, 1'b0, randBit(use_pat));
            if (tbl_beats[i] != 0) begin
                cur = tbl_ctrl[i];
                pushCycle(cur, 1'b0, 1'b1, 1'b0, randBit(use_pat));
                rem = tbl_beats[i];
                while (rem > 0) begin
                    if (use_pat) begin
                        bt = pat[pb];
                        pb++;
                    end else begin
                        bt = randBit(1'b0);
                    end
                    pushCycle(cur, 1'b1, 1'b1, 1'b0, bt);
                    if (bt) rem--;
                end
            end
        end
        pushCycle(cur, 1'b0, 1'b0, 1'b1, randBit(use_pat));
        pushCycle(cur, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < q_ctrl.size(); c++) begin
            st = (c == 0) || (!use_pat && (q_busy[c] || q_done[c]) && ($urandom_range(0, 3) == 0));
            we = !use_pat && q_busy[c] && ($urandom_range(0, 3) == 0);
            applyStimulus(st, (AW+1)'(n), q_beat[c], we, AW'($urandom_range(0, DEPTH-1)),
                          {BEAT_W'($urandom), 4'($urandom), 32'($urandom)});
            checkOutput($sformatf("n%0d c%0d ctrl", n, c), 64'(ctrl), 64'(q_ctrl[c]));
            checkOutput($sformatf("n%0d c%0d route_en", n, c), 64'(route_en), 64'(q_en[c]));
            checkOutput($sformatf("n%0d c%0d busy", n, c), 64'(busy), 64'(q_busy[c]));
            checkOutput($sformatf("n%0d c%0d done", n, c), 64'(done), 64'(q_done[c]));
            checkOutput($sformatf("n%0d c%0d err", n, c), 64'(err), 64'((c == 0) ? model_err : 1'b0));
        end
        model_ctrl = cur;
        model_err  = 1'b0;
    endtask

    initial begin
        clearModel();

        // Power-on reset, then a stray beat in IDLE
        #3;
        checkReset("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 5'd1, 1'b1, 1'b0, '0, '0);
        applyStimulus(1'b0, 5'd1, 1'b0, 1'b0, '0, '0);
        checkReset("idle after beat");

        // Two-entry run with beats in cycles 3, 5, 6 and 9
        writeEntry(0, 3, 36'h0_0000_0009);
        writeEntry(1, 1, 36'h9_0000_0000);
        runOne(2, 1'b1, 32'h0000_001D);

        // Zero-beat entry in the middle is skipped
        writeEntry(0, 2, 36'h1_2345_6789);
        writeEntry(1, 0, 36'hA_AAAA_AAAA);
        writeEntry(2, 2, 36'h5_5555_5555);
        runOne(3, 1'b1, 32'h0000_000F);

        // Illegal counts set err and never leave IDLE
        applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 5'd17, 1'b0, 1'b0, '0, '0);
        checkOutput("illegal0 err", 64'(err), 64'(1));
        checkOutput("illegal0 busy", 64'(busy), 64'(0));
        applyStimulus(1'b0, 5'd17, 1'b0, 1'b0, '0, '0);
        checkOutput("illegal17 err", 64'(err), 64'(1));
        checkOutput("illegal17 busy", 64'(busy), 64'(0));
        checkOutput("illegal17 ctrl", 64'(ctrl), 64'(model_ctrl));
        model_err = 1'b1;
        runOne(3, 1'b0, 32'h0);

        // Randomized tables and run lengths with noise on ignored inputs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                writeEntry(i, $urandom_range(0, 3), {4'($urandom), 32'($urandom)});
            end
            runOne($urandom_range(1, DEPTH), 1'b0, 32'h0);
        end

        // Reset asserted mid-cycle while running with cnt=2
        writeEntry(0, 3, 36'h3_0000_0003);
        applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 5'd1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 5'd1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 5'd1, 1'b1, 1'b0, '0, '0);
        applyStimulus(1'b0, 5'd1, 1'b0, 1'b0, '0, '0);
        checkOutput("prerst route_en", 64'(route_en), 64'(1));
        checkOutput("prerst ctrl", 64'(ctrl), 64'(36'h3_0000_0003));
        #2 rst = 1'b1;
        #1 checkReset("midrun rst");
        @(negedge clk);
        rst = 1'b0;
        clearModel();
        applyStimulus(1'b0, 5'd1, 1'b1, 1'b0, '0, '0);

        // Cleared table: every entry is skipped
        runOne(3, 1'b0, 32'h0);

        // Reprogrammed run behaves like the first one
        writeEntry(0, 3, 36'h0_0000_0009);
        writeEntry(1, 1, 36'h9_0000_0000);
        runOne(2, 1'b1, 32'h0000_001D);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
